afifo_read_packer: RTL

- Read-domain consumer that sits directly downstream of the asynchronous FIFO and runs entirely on the FIFO read clock.
- Drains narrow DataSize entries through the FIFO Pop/empty/DataOut interface and packs PackCount entries, LSB-first, into one wide word.
- Presents the packed word on a valid/ready output with a one-entry holding register.
- A Flush request emits a partially filled word.

---
 rtl/afifo_pkg.sv | 20 ++
 rtl/afifo_out_reg.sv | 32 +++
 rtl/afifo_read_packer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/afifo_pkg.sv
// Shared definitions for the asynchronous FIFO and its read-side consumers:
// default geometry, the read packer state type and width helpers.
package afifo_pkg;

    localparam int DEFAULT_DATA_SIZE = 3;
    localparam int DEFAULT_ADDR_SIZE = 4;

    // FILL: draining entries into the pack register.
    // HOLD: pack register holds a complete word waiting for the output register.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

    // Width needed to count 0..pack_count valid slots.
    function automatic int count_width(input int pack_count);
        return $clog2(pack_count + 1);
    endfunction

endpackage

// File: rtl/afifo_out_reg.sv
// One-entry valid/ready holding register. A load is only issued while the
// register is free (empty, or being accepted on the same edge).
module afifo_out_reg #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [Width-1:0] data,
    output logic             free
);

    assign free = !valid || ready;

    // Hold the word until accepted; a same-edge reload keeps valid high.
    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/afifo_read_packer.sv
// Read-domain packer: pops narrow entries from the async FIFO and packs
// PackCount of them LSB-first into one wide word on a valid/ready output.
// A Flush request emits a partially filled word with unused slots zeroed.
module afifo_read_packer
    import afifo_pkg::*;
#(
    parameter  int DataSize   = DEFAULT_DATA_SIZE,
    parameter  int PackCount  = 4,
    localparam int OutWidth   = DataSize * PackCount,
    localparam int CountWidth = count_width(PackCount)
) (
    input  logic                  Rclk,
    input  logic                  Rreset,
    input  logic                  empty,
    output logic                  Pop,
    input  logic [DataSize-1:0]   DataOut,
    input  logic                  Flush,
    output logic [OutWidth-1:0]   OutData,
    output logic [CountWidth-1:0] OutCount,
    output logic                  OutValid,
    input  logic                  OutReady
);

    localparam logic [CountWidth-1:0] FULL_COUNT = CountWidth'(PackCount);
    localparam logic [CountWidth-1:0] LAST_SLOT  = CountWidth'(PackCount - 1);

    pack_state_t state_q, state_d;
    logic [OutWidth-1:0]   pack_q, pack_d;
    logic [CountWidth-1:0] fill_q, fill_d;
    logic                  inflight_q;
    logic                  flush_pend_q, flush_pend_d;
    logic [CountWidth:0]   occupancy;
    logic                  word_done;
    logic [OutWidth-1:0]   flush_word;

    logic                  out_load;
    logic                  out_free;
    logic [OutWidth-1:0]   load_data;
    logic [CountWidth-1:0] load_count;
    logic [CountWidth+OutWidth-1:0] out_word;

    // Slots already captured plus the one still in flight.
    assign occupancy = {1'b0, fill_q} + {{CountWidth{1'b0}}, inflight_q};

    assign Pop = !Rreset && !empty && (state_q == FILL) && !flush_pend_q
                 && (occupancy < (CountWidth + 1)'(PackCount));

    // The in-flight entry lands in the last free slot this edge.
    assign word_done = inflight_q && (fill_q == LAST_SLOT);

    // Partial word for a flush: slots at or above fill are forced to zero.
    always_comb begin
        flush_word = pack_q;
        for (int i = 0; i < PackCount; i++) begin
            if (i >= int'(fill_q)) begin
                flush_word[i*DataSize +: DataSize] = '0;
            end
        end
    end

    // Next-state, capture and output-load decisions.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        pack_d       = pack_q;
        fill_d       = fill_q;
        flush_pend_d = flush_pend_q;
        out_load     = 1'b0;
        load_data    = pack_q;
        load_count   = FULL_COUNT;

        if (inflight_q) begin
            pack_d[int'(fill_q)*DataSize +: DataSize] = DataOut;
            fill_d = fill_q + 1'b1;
        end

        case (state_q)
            FILL: begin
                if (word_done) begin
                    // A completing capture wins over any pending flush.
                    flush_pend_d = 1'b0;
                    if (out_free) begin
                        out_load  = 1'b1;
                        load_data = pack_d;
                        fill_d    = '0;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (flush_pend_q) begin
                    if (!inflight_q && out_free) begin
                        out_load     = 1'b1;
                        load_data    = flush_word;
                        load_count   = fill_q;
                        fill_d       = '0;
                        flush_pend_d = 1'b0;
                    end
                end else if (Flush && (occupancy != '0)) begin
                    flush_pend_d = 1'b1;
                end
            end
            HOLD: begin
                // Output register drains this edge; refill it from the packer.
                if (out_free) begin
                    out_load  = 1'b1;
                    load_data = pack_q;
                    fill_d    = '0;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Control state; an in-flight read is dropped by reset.
    always_ff @(posedge Rclk or posedge Rreset) begin
        if (Rreset) begin
            state_q      <= FILL;
            fill_q       <= '0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            inflight_q   <= Pop;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Pack slots; contents above fill are never observed.
    // NOTE: the slot storage carries no reset since fill gates every use of it.
    always_ff @(posedge Rclk) begin
        pack_q <= pack_d;
    end

    afifo_out_reg #(
        .Width(CountWidth + OutWidth)
    ) u_out_reg (
        .clk      (Rclk),
        .rst      (Rreset),
        .load     (out_load),
        .load_data({load_count, load_data}),
        .ready    (OutReady),
        .valid    (OutValid),
        .data     (out_word),
        .free     (out_free)
    );

    assign OutData  = out_word[OutWidth-1:0];
    assign OutCount = out_word[OutWidth +: CountWidth];

endmodule
